// File: rtl/lsu_pkg.sv
// Shared funct3 encodings and FSM state type for the memory-stage load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_DATA,
    DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, access legality checks, and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        bad_access,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves a latch behind.
    be         = 4'b1111;
    wdata      = store_data;
    bad_access = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        F3_SH: begin
          be         = 4'b0011 << {addr_lo[1], 1'b0};
          wdata      = {2{store_data[15:0]}};
          bad_access = addr_lo[0];
        end
        F3_SW:   bad_access = |addr_lo;
        default: bad_access = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: bad_access = 1'b0;
        F3_LH, F3_LHU: bad_access = addr_lo[0];
        F3_LW:         bad_access = |addr_lo;
        default:       bad_access = 1'b1;
      endcase
    end
  end

  always_comb begin
    lane_byte = load_word[{addr_lo, 3'b000} +: 8];
    lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    case (funct3)
      F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_LBU:  load_data = {24'h0, lane_byte};
      F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_LHU:  load_data = {16'h0, lane_half};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage data-memory interface: issues req/gnt/rvalid transactions and stalls the
// upstream pipeline until each access completes. Datapath outputs are combinational.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_memren,
  input  logic              m_memwren,
  input  logic [AWIDTH-1:0] m_alu_res,
  input  logic [DWIDTH-1:0] m_rs2data,
  input  logic [2:0]        m_funct3,
  input  logic              pipe_hold,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [AWIDTH-1:0] dmem_addr,
  output logic [DWIDTH-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DWIDTH-1:0] dmem_rdata,
  output logic [DWIDTH-1:0] m_mem_data,
  output logic              lsu_stall,
  output logic              misalign_exc
);

  lsu_state_e        state;
  logic [DWIDTH-1:0] rdata_q;
  logic [DWIDTH-1:0] load_data;
  logic              access;
  logic              bad_access;
  logic              start;
  logic              req_phase;

  lsu_align u_align (
    .addr_lo    (m_alu_res[1:0]),
    .funct3     (m_funct3),
    .is_store   (m_memwren),
    .store_data (m_rs2data),
    .load_word  (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .bad_access (bad_access),
    .load_data  (load_data)
  );

  assign access    = m_memren | m_memwren;
  assign start     = (state == IDLE) && access && !bad_access;
  // EX/MEM is frozen while stalled, so address/data stay stable through WAIT_GNT.
  assign req_phase = start || (state == WAIT_GNT);

  assign dmem_req     = !reset && req_phase;
  assign dmem_we      = m_memwren;
  assign dmem_addr    = {m_alu_res[AWIDTH-1:2], 2'b00};
  assign lsu_stall    = !reset && (req_phase || (state == WAIT_DATA));
  assign misalign_exc = !reset && (state == IDLE) && access && bad_access;
  assign m_mem_data   = (!reset && (state == DONE)) ? rdata_q : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE, WAIT_GNT: begin
          if (req_phase) begin
            if (!dmem_gnt) begin
              state <= WAIT_GNT;
            end else if (m_memwren) begin
              state   <= DONE;
              rdata_q <= '0;
            end else begin
              state <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (dmem_rvalid) begin
            rdata_q <= load_data;
            state   <= DONE;
          end
        end
        DONE: begin
          if (!pipe_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
